// File: rtl/ysyx_23060203_redirect_ctrl.sv
// Redirect sequencer: one committed control-flow event at a time -> flush, drain, optional icache invalidate, new PC.
// Define FENCEI_INV_EN to route fence.i through the icache invalidate handshake.
module ysyx_23060203_redirect_ctrl #(
    parameter int DRAIN_MAX    = 255,
    parameter int MCAUSE_ECALL = 11
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ev_valid,
    output logic        ev_ready,
    input  logic [1:0]  ev_type,
    input  logic [31:0] ev_pc,
    input  logic [31:0] ev_dnpc,
    input  logic [31:0] csr_mtvec,
    input  logic [31:0] csr_mepc,
    output logic        trap_wen,
    output logic [31:0] trap_mepc,
    output logic [31:0] trap_mcause,
    output logic        ifu_flush,
    output logic        idu_flush,
    output logic        exu_flush,
    input  logic        ifu_busy,
    input  logic        lsu_busy,
    output logic        icache_inv_req,
    input  logic        icache_inv_ack,
    output logic        redir_valid,
    input  logic        redir_ready,
    output logic [31:0] redir_pc,
    output logic        drain_err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRAIN,
        S_INV,
        S_REDIR
    } state_e;

    typedef enum logic [1:0] {
        EV_JMP    = 2'd0,
        EV_ECALL  = 2'd1,
        EV_MRET   = 2'd2,
        EV_FENCEI = 2'd3
    } ev_kind_e;

`ifdef FENCEI_INV_EN
    localparam bit INV_EN = 1'b1;
`else
    localparam bit INV_EN = 1'b0;
`endif

    localparam logic [7:0]  DRAIN_LIMIT = 8'(DRAIN_MAX);
    localparam logic [31:0] CAUSE_ECALL = 32'(MCAUSE_ECALL);

    state_e      state_q, state_d;
    ev_kind_e    kind_q, kind_d;
    logic [31:0] target_q, target_d;
    logic [31:0] pc_q, pc_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        entry_q, entry_d;
    logic        err_q, err_d;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            kind_q   <= EV_JMP;
            target_q <= '0;
            pc_q     <= '0;
            cnt_q    <= '0;
            entry_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            kind_q   <= kind_d;
            target_q <= target_d;
            pc_q     <= pc_d;
            cnt_q    <= cnt_d;
            entry_q  <= entry_d;
            err_q    <= err_d;
        end
    end

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d  = state_q;
        kind_d   = kind_q;
        target_d = target_q;
        pc_d     = pc_q;
        cnt_d    = cnt_q;
        entry_d  = 1'b0;
        err_d    = err_q;

        unique case (state_q)
            S_IDLE: begin
                if (ev_valid) begin
                    kind_d  = ev_kind_e'(ev_type);
                    pc_d    = ev_pc;
                    cnt_d   = '0;
                    entry_d = 1'b1;
                    state_d = S_DRAIN;
                    unique case (ev_kind_e'(ev_type))
                        EV_ECALL: target_d = {csr_mtvec[31:2], 2'b00};
                        EV_MRET:  target_d = csr_mepc;
                        default:  target_d = ev_dnpc;
                    endcase
                end
            end
            S_DRAIN: begin
                // Busy is checked before the timeout so a clean exit never flags an error.
                if (!ifu_busy && !lsu_busy) begin
                    state_d = (INV_EN && kind_q == EV_FENCEI) ? S_INV : S_REDIR;
                end else if (cnt_q == DRAIN_LIMIT) begin
                    err_d   = 1'b1;
                    state_d = (INV_EN && kind_q == EV_FENCEI) ? S_INV : S_REDIR;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_INV: begin
                if (icache_inv_ack) state_d = S_REDIR;
            end
            S_REDIR: begin
                if (redir_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ev_ready is masked by reset so every output reads 0 while reset is held.
    assign ev_ready       = (state_q == S_IDLE) && !reset;
    assign ifu_flush      = entry_q;
    assign idu_flush      = entry_q;
    assign exu_flush      = entry_q;
    assign trap_wen       = entry_q && (kind_q == EV_ECALL);
    assign trap_mepc      = trap_wen ? pc_q : '0;
    assign trap_mcause    = trap_wen ? CAUSE_ECALL : '0;
    assign icache_inv_req = INV_EN ? (state_q == S_INV) : 1'b0;
    assign redir_valid    = (state_q == S_REDIR);
    assign redir_pc       = redir_valid ? target_q : '0;
    assign drain_err      = err_q;

endmodule

// File: tb/tb_ysyx_23060203_redirect_ctrl.sv
// Scoreboard bench for ysyx_23060203_redirect_ctrl; expected redirects/traps are queued at issue and
// compared when the DUT handshakes. Honours FENCEI_INV_EN the same way the design does.
module tb_ysyx_23060203_redirect_ctrl;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        ev_valid = 1'b0;
    logic        ev_ready;
    logic [1:0]  ev_type = 2'd0;
    logic [31:0] ev_pc = '0;
    logic [31:0] ev_dnpc = '0;
    logic [31:0] csr_mtvec = '0;
    logic [31:0] csr_mepc = '0;
    logic        trap_wen;
    logic [31:0] trap_mepc;
    logic [31:0] trap_mcause;
    logic        ifu_flush, idu_flush, exu_flush;
    logic        ifu_busy = 1'b0;
    logic        lsu_busy = 1'b0;
    logic        icache_inv_req;
    logic        icache_inv_ack = 1'b0;
    logic        redir_valid;
    logic        redir_ready = 1'b0;
    logic [31:0] redir_pc;
    logic        drain_err;

    ysyx_23060203_redirect_ctrl dut (
        .clock          (clock),
        .reset          (reset),
        .ev_valid       (ev_valid),
        .ev_ready       (ev_ready),
        .ev_type        (ev_type),
        .ev_pc          (ev_pc),
        .ev_dnpc        (ev_dnpc),
        .csr_mtvec      (csr_mtvec),
        .csr_mepc       (csr_mepc),
        .trap_wen       (trap_wen),
        .trap_mepc      (trap_mepc),
        .trap_mcause    (trap_mcause),
        .ifu_flush      (ifu_flush),
        .idu_flush      (idu_flush),
        .exu_flush      (exu_flush),
        .ifu_busy       (ifu_busy),
        .lsu_busy       (lsu_busy),
        .icache_inv_req (icache_inv_req),
        .icache_inv_ack (icache_inv_ack),
        .redir_valid    (redir_valid),
        .redir_ready    (redir_ready),
        .redir_pc       (redir_pc),
        .drain_err      (drain_err)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    typedef struct packed {
        logic [31:0] mepc;
        logic [31:0] mcause;
    } trap_t;

    logic [31:0] exp_redir[$];
    trap_t       exp_trap[$];
    int          flush_cnt = 0;
    int          trap_cnt  = 0;
    int          inv_cnt   = 0;
    int          redir_cnt = 0;

    function automatic logic [31:0] model_target(input logic [1:0] t, input logic [31:0] dnpc);
        case (t)
            2'd1:    return {csr_mtvec[31:2], 2'b00};
            2'd2:    return csr_mepc;
            default: return dnpc;
        endcase
    endfunction

    // Output monitor: samples on the falling edge, pops the scoreboard on each trap write and redirect handshake.
    always @(negedge clock) begin
        if (!reset) begin
            if (ifu_flush || idu_flush || exu_flush) begin
                flush_cnt++;
                check("flush_align", {30'd0, idu_flush, exu_flush}, {30'd0, ifu_flush, ifu_flush});
            end
            if (trap_wen) begin
                trap_t tr;
                trap_cnt++;
                check("trap_pending", 32'(exp_trap.size() > 0), 32'd1);
                check("trap_on_entry", 32'(ifu_flush), 32'd1);
                if (exp_trap.size() > 0) begin
                    tr = exp_trap.pop_front();
                    check("trap_mepc", trap_mepc, tr.mepc);
                    check("trap_mcause", trap_mcause, tr.mcause);
                end
            end
            if (icache_inv_req) inv_cnt++;
            if (redir_valid && redir_ready) begin
                redir_cnt++;
                check("redir_pending", 32'(exp_redir.size() > 0), 32'd1);
                if (exp_redir.size() > 0) check("redir_pc", redir_pc, exp_redir.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic send(input logic [1:0] t, input logic [31:0] pc, input logic [31:0] dnpc);
        int    n = 0;
        trap_t tr;
        while (!ev_ready && n < 100) begin
            step();
            n++;
        end
        check("send_ready", 32'(ev_ready), 32'd1);
        ev_valid = 1'b1;
        ev_type  = t;
        ev_pc    = pc;
        ev_dnpc  = dnpc;
        exp_redir.push_back(model_target(t, dnpc));
        if (t == 2'd1) begin
            tr.mepc   = pc;
            tr.mcause = 32'd11;
            exp_trap.push_back(tr);
        end
        step();
        ev_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!(ev_ready && exp_redir.size() == 0) && n < 1000) begin
            @(negedge clock);
            n++;
        end
        check("idle_reached", 32'(ev_ready && exp_redir.size() == 0), 32'd1);
        step();
    endtask

    function automatic logic [31:0] ctrl_outs();
        return {23'd0, ev_ready, trap_wen, ifu_flush, idu_flush, exu_flush,
                icache_inv_req, redir_valid, drain_err, 1'b0};
    endfunction

    initial begin
        int f0, t0, i0, r0, n;

        // Reset: everything quiet, ev_ready rises only after release.
        repeat (3) @(posedge clock);
        #1;
        check("reset_ctrl", ctrl_outs(), 32'd0);
        check("reset_redir_pc", redir_pc, 32'd0);
        check("reset_trap_mepc", trap_mepc, 32'd0);
        check("reset_trap_mcause", trap_mcause, 32'd0);
        reset = 1'b0;
        #1;
        check("ready_after_reset", 32'(ev_ready), 32'd1);
        step();

        // JMP, idle core: flush at T+1, redirect at T+2, ready again at T+3.
        redir_ready = 1'b1;
        f0 = flush_cnt;
        t0 = trap_cnt;
        send(2'd0, 32'h8000_0000, 32'h8000_0100);
        @(negedge clock);
        check("jmp_flush_t1", 32'(ifu_flush), 32'd1);
        check("jmp_no_trap", 32'(trap_wen), 32'd0);
        check("jmp_no_redir_t1", 32'(redir_valid), 32'd0);
        check("jmp_busy_t1", 32'(ev_ready), 32'd0);
        @(negedge clock);
        check("jmp_redir_t2", 32'(redir_valid), 32'd1);
        check("jmp_redir_pc_t2", redir_pc, 32'h8000_0100);
        check("jmp_flush_gone", 32'(ifu_flush), 32'd0);
        @(negedge clock);
        check("jmp_ready_t3", 32'(ev_ready), 32'd1);
        check("jmp_redir_done", 32'(redir_valid), 32'd0);
        check("jmp_one_flush", 32'(flush_cnt - f0), 32'd1);
        check("jmp_trap_count", 32'(trap_cnt - t0), 32'd0);
        step();

        // ECALL: trap write with latched pc, target aligned from mtvec.
        csr_mtvec = 32'h8000_1003;
        t0 = trap_cnt;
        send(2'd1, 32'h8000_0040, 32'h8000_0044);
        wait_idle();
        check("ecall_trap_count", 32'(trap_cnt - t0), 32'd1);

        // MRET with lsu_busy for 5 cycles of DRAIN.
        csr_mepc = 32'h8000_0044;
        lsu_busy = 1'b1;
        send(2'd2, 32'h8000_0080, 32'h8000_0084);
        for (int i = 0; i < 5; i++) begin
            check("mret_held_in_drain", 32'(redir_valid), 32'd0);
            step();
        end
        lsu_busy = 1'b0;
        @(negedge clock);
        check("mret_exit_cycle", 32'(redir_valid), 32'd0);
        @(negedge clock);
        check("mret_redir", 32'(redir_valid), 32'd1);
        check("mret_redir_pc", redir_pc, 32'h8000_0044);
        check("mret_no_err", 32'(drain_err), 32'd0);
        wait_idle();

        // Back-pressure: redir_ready low for 4 cycles, offer must hold still.
        redir_ready = 1'b0;
        send(2'd0, 32'h8000_0100, 32'h8000_0200);
        n = 0;
        while (!redir_valid && n < 20) begin
            step();
            n++;
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            check("hold_valid", 32'(redir_valid), 32'd1);
            check("hold_pc", redir_pc, 32'h8000_0200);
            check("hold_not_ready", 32'(ev_ready), 32'd0);
        end
        step();
        redir_ready = 1'b1;
        wait_idle();

        // FENCEI: invalidate handshake with ack on the 3rd request cycle, or no request at all.
        i0 = inv_cnt;
        send(2'd3, 32'h8000_0100, 32'h8000_0104);
`ifdef FENCEI_INV_EN
        n = 0;
        for (int k = 0; k < 20; k++) begin
            if (icache_inv_req) begin
                n++;
                if (n == 3) icache_inv_ack = 1'b1;
            end
            step();
            icache_inv_ack = 1'b0;
            if (n == 3) break;
        end
        check("fencei_req_drop", 32'(icache_inv_req), 32'd0);
        check("fencei_redir", 32'(redir_valid), 32'd1);
        wait_idle();
        check("fencei_inv_cycles", 32'(inv_cnt - i0), 32'd3);
`else
        icache_inv_ack = 1'b1;
        step();
        icache_inv_ack = 1'b0;
        wait_idle();
        check("fencei_no_inv", 32'(inv_cnt - i0), 32'd0);
`endif

        // ifu_busy stuck: timeout sets drain_err and the redirect still goes out.
        check("err_clear_before", 32'(drain_err), 32'd0);
        ifu_busy = 1'b1;
        send(2'd0, 32'h8000_0200, 32'h8000_0300);
        n = 0;
        for (int k = 0; k < 400; k++) begin
            @(negedge clock);
            if (redir_valid) break;
            n++;
        end
        check("drain_len_ok", 32'(n >= 255 && n <= 257), 32'd1);
        check("drain_err_set", 32'(drain_err), 32'd1);
        step();
        ifu_busy = 1'b0;
        wait_idle();
        check("drain_err_sticky", 32'(drain_err), 32'd1);

        // Reset mid-sequence: abort, no redirect or trap afterwards, drain_err cleared.
`ifdef FENCEI_INV_EN
        send(2'd3, 32'h8000_0300, 32'h8000_0304);
        n = 0;
        while (!icache_inv_req && n < 20) begin
            step();
            n++;
        end
        check("reset_in_inv", 32'(icache_inv_req), 32'd1);
`else
        ifu_busy = 1'b1;
        send(2'd1, 32'h8000_0300, 32'h8000_0304);
        step();
        step();
`endif
        reset = 1'b1;
        exp_redir.delete();
        exp_trap.delete();
        #1;
        check("abort_ctrl", ctrl_outs(), 32'd0);
        check("abort_redir_pc", redir_pc, 32'd0);
        step();
        check("abort_ctrl_held", ctrl_outs(), 32'd0);
        ifu_busy = 1'b0;
        reset = 1'b0;
        #1;
        check("abort_ready", 32'(ev_ready), 32'd1);
        r0 = redir_cnt;
        t0 = trap_cnt;
        for (int i = 0; i < 5; i++) begin
            step();
            check("abort_quiet", {30'd0, redir_valid, icache_inv_req}, 32'd0);
        end
        check("abort_no_redir", 32'(redir_cnt - r0), 32'd0);
        check("abort_no_trap", 32'(trap_cnt - t0), 32'd0);

        // Normal operation resumes.
        send(2'd0, 32'h8000_0400, 32'h8000_0500);
        wait_idle();
        check("redir_queue_empty", 32'(exp_redir.size()), 32'd0);
        check("trap_queue_empty", 32'(exp_trap.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
